uart_rx_fifo: RTL

Parametrised, oversampling UART receiver with input synchronisation, majority-vote bit sampling, configurable stop bits, optional parity and a built-in first-word-fall-through receive FIFO. Serial data on `rxd` is assembled into words and presented on an AXI4-Stream master port. The block sits between the SoC UART pad and the UART register/APB front end. It is the successor to the single-register UART receiver and adds buffering, a glitch filter and richer error reporting.

---
 rtl/uart_rx_fifo_if.sv | 12 +
 rtl/uart_rx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// AXI4-Stream style receive-data channel between uart_rx_fifo and its consumer.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote sampling and FWFT receive FIFO.
// Optional parity bit is built only when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    input  logic [15:0]                   prescale,
    input  logic                          stop_bits,
`ifdef UART_RX_PARITY_EN
    input  logic                          parity_odd,
`endif
    uart_rx_fifo_if.master                m_axis,
    output logic                          busy,
    output logic                          overrun_error,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t                  r_state, w_state_nxt;
    logic [SYNC_STAGES-2:0]  r_sync;
    logic [2:0]              r_hist;
    logic [18:0]             r_cnt, w_cnt_nxt;
    logic [18:0]             r_period, w_period_nxt;
    logic                    r_stop2, w_stop2_nxt;
    logic                    r_stop_idx, w_stop_idx_nxt;
    logic [BW-1:0]           r_bit, w_bit_nxt;
    logic [DATA_WIDTH-1:0]   r_shift, w_shift_nxt;
    logic                    r_ferr, r_ovr;
    logic                    w_maj, w_fall, w_tick, w_push, w_ferr, w_tag;
    logic [15:0]             w_pre;
    logic [18:0]             w_period_in;

    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wptr, r_rptr;
    logic [CW-1:0]           r_count;
    logic                    w_pop, w_full, w_wr, w_ovr;

`ifdef UART_RX_PARITY_EN
    logic                    r_tag, w_tag_nxt;
    logic                    r_perr, w_perr;
    logic                    r_tmem [FIFO_DEPTH];
`endif

    // The youngest history bit doubles as the last synchroniser stage, so the
    // edge detector sees rxd SYNC_STAGES clocks after the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_hist <= '1;
        end else begin
            r_sync <= (SYNC_STAGES-1)'({r_sync, rxd});
            r_hist <= {r_hist[1:0], r_sync[SYNC_STAGES-2]};
        end
    end

    assign w_maj       = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
    assign w_fall      = r_hist[1] & ~r_hist[0];
    assign w_tick      = (r_cnt == '0);
    assign w_pre       = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_period_in = {w_pre, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_tick ? r_cnt : r_cnt - 19'd1;
        w_period_nxt   = r_period;
        w_stop2_nxt    = r_stop2;
        w_stop_idx_nxt = r_stop_idx;
        w_bit_nxt      = r_bit;
        w_shift_nxt    = r_shift;
        w_push         = 1'b0;
        w_ferr         = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_tag_nxt      = r_tag;
        w_perr         = 1'b0;
`endif
        case (r_state)
            S_IDLE: if (w_fall) begin
                w_cnt_nxt    = {1'b0, w_pre, 2'b00} - 19'd1;
                w_period_nxt = w_period_in;
                w_stop2_nxt  = stop_bits;
`ifdef UART_RX_PARITY_EN
                w_tag_nxt    = 1'b0;
`endif
                w_state_nxt  = S_START;
            end
            S_START: if (w_tick) begin
                if (w_maj) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_period - 19'd1;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: if (w_tick) begin
                w_shift_nxt = {w_maj, r_shift[DATA_WIDTH-1:1]};
                w_cnt_nxt   = r_period - 19'd1;
                if (r_bit == BW'(DATA_WIDTH-1)) begin
                    w_stop_idx_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
                    w_state_nxt    = S_PARITY;
`else
                    w_state_nxt    = S_STOP;
`endif
                end else begin
                    w_bit_nxt = r_bit + BW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_tick) begin
                w_cnt_nxt   = r_period - 19'd1;
                w_state_nxt = S_STOP;
                if (w_maj != (^r_shift ^ parity_odd)) begin
                    w_tag_nxt = 1'b1;
                    w_perr    = 1'b1;
                end
            end
`endif
            S_STOP: if (w_tick) begin
                if (!w_maj) begin
                    w_ferr      = 1'b1;
                    w_state_nxt = S_BREAK;
                end else if (r_stop_idx == r_stop2) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stop_idx_nxt = 1'b1;
                    w_cnt_nxt      = r_period - 19'd1;
                end
            end
            S_BREAK: if (r_hist[0]) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_period   <= '0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_tag      <= 1'b0;
            r_perr     <= 1'b0;
`endif
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_period   <= w_period_nxt;
            r_stop2    <= w_stop2_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_ferr     <= w_ferr;
            r_ovr      <= w_ovr;
`ifdef UART_RX_PARITY_EN
            r_tag      <= w_tag_nxt;
            r_perr     <= w_perr;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign w_tag = r_tag;
`else
    assign w_tag = 1'b0;
`endif

    // A full FIFO still accepts a word when the head is popped the same cycle.
    assign w_pop  = m_axis.tvalid & m_axis.tready;
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_ovr  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

    assign m_axis.tvalid = (r_count != '0);
    assign m_axis.tdata  = m_axis.tvalid ? r_mem[r_rptr] : '0;

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (w_wr) r_tmem[r_wptr] <= w_tag;
    end
    assign m_axis.tuser = m_axis.tvalid ? r_tmem[r_rptr] : 1'b0;
    assign parity_error = r_perr;
`else
    assign m_axis.tuser = w_tag;
    assign parity_error = 1'b0;
`endif

    assign busy          = (r_state != S_IDLE);
    assign frame_error   = r_ferr;
    assign overrun_error = r_ovr;
    assign fifo_count    = r_count;
endmodule
